// File: rtl/calc_pkg.sv
// Shared constants for the calculator arbiter: opcodes, FSM states, default operand width.
package calc_pkg;

    localparam int unsigned CALC_WIDTH = 7;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_SOMA  = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_MULTI = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/calc_arbiter_if.sv
// Requester-side bus of the calculator arbiter: two request/operand sets plus shared result.
interface calc_arbiter_if #(
    parameter int unsigned WIDTH = calc_pkg::CALC_WIDTH
);
    logic [1:0]         req;
    logic [1:0]         op0;
    logic [WIDTH-1:0]   a0;
    logic [WIDTH-1:0]   b0;
    logic [1:0]         op1;
    logic [WIDTH-1:0]   a1;
    logic [WIDTH-1:0]   b1;
    logic [1:0]         gnt;
    logic [1:0]         done;
    logic [2*WIDTH-1:0] y;
    logic               sinal;
    logic               busy;

    modport master (
        output req, op0, a0, b0, op1, a1, b1,
        input  gnt, done, y, sinal, busy
    );

    modport slave (
        input  req, op0, a0, b0, op1, a1, b1,
        output gnt, done, y, sinal, busy
    );
endinterface

// File: rtl/calc_shift_mult.sv
// Sequential shift-add multiplier: first partial product taken on start, ready pulses WIDTH cycles later.
module calc_shift_mult #(
    parameter int unsigned WIDTH = calc_pkg::CALC_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] p
);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p      <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            ready  <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (start) begin
                p      <= b[0] ? RW'(a) : '0;
                mcand  <= RW'(a) << 1;
                mplier <= b >> 1;
                cnt    <= CW'(1);
                busy   <= 1'b1;
            end else if (busy) begin
                p      <= p + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                // last partial product lands this edge
                if (cnt == CW'(WIDTH - 1)) begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Two-requester front end to a shared add/sub/multiply unit with round-robin arbitration.
// Define CALC_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    calc_arbiter_if.slave bus
);
    localparam int unsigned RW = 2 * WIDTH;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             win_q;
`ifndef CALC_ARB_FIXED_PRIO_EN
    logic             rr_q;
`endif

    logic [1:0]       gnt_q, done_q, gnt_nxt, done_nxt;
    logic [RW-1:0]    y_q, y_nxt;
    logic             sinal_q, sinal_nxt, busy_q, busy_nxt;

    logic             win_c, load_c, start_c;
    logic [1:0]       sel_op_c;
    logic [WIDTH-1:0] sel_a_c, sel_b_c;

    logic             mult_busy, mult_ready;
    logic [RW-1:0]    mult_p;

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.y     = y_q;
    assign bus.sinal = sinal_q;
    assign bus.busy  = busy_q;

    // Winner selection and operand mux for the requester about to be granted
    always_comb begin : arbitrate
        win_c = 1'b0;
`ifdef CALC_ARB_FIXED_PRIO_EN
        win_c = ~bus.req[0];
`else
        if (bus.req == 2'b11) win_c = ~rr_q;
        else                  win_c = bus.req[1];
`endif
        sel_op_c = win_c ? bus.op1 : bus.op0;
        sel_a_c  = win_c ? bus.a1  : bus.a0;
        sel_b_c  = win_c ? bus.b1  : bus.b0;
    end

    assign load_c  = (state == IDLE) && (bus.req != 2'b00);
    assign start_c = load_c && (sel_op_c == OP_MULTI);

    calc_shift_mult #(.WIDTH(WIDTH)) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_c),
        .a     (sel_a_c),
        .b     (sel_b_c),
        .busy  (mult_busy),
        .ready (mult_ready),
        .p     (mult_p)
    );

    always_comb begin : next_state
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req != 2'b00) state_nxt = EXEC;
            EXEC:    if (op_q != OP_MULTI || mult_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin : outputs
        gnt_nxt   = 2'b00;
        done_nxt  = 2'b00;
        y_nxt     = y_q;
        sinal_nxt = sinal_q;
        busy_nxt  = (state_nxt != IDLE) || mult_busy;
        if (load_c) gnt_nxt = win_c ? 2'b10 : 2'b01;
        if (state == EXEC && state_nxt == DONE) begin
            done_nxt  = win_q ? 2'b10 : 2'b01;
            sinal_nxt = 1'b0;
            case (op_q)
                OP_SOMA:  y_nxt = RW'(a_q) + RW'(b_q);
                OP_SUB: begin
                    if (b_q > a_q) begin
                        y_nxt     = RW'(b_q - a_q);
                        sinal_nxt = 1'b1;
                    end else begin
                        y_nxt = RW'(a_q - b_q);
                    end
                end
                OP_MULTI: y_nxt = mult_p;
                default:  y_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_CLEAR;
            a_q     <= '0;
            b_q     <= '0;
            win_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            y_q     <= '0;
            sinal_q <= 1'b0;
            busy_q  <= 1'b0;
`ifndef CALC_ARB_FIXED_PRIO_EN
            rr_q    <= 1'b1;
`endif
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_nxt;
            done_q  <= done_nxt;
            y_q     <= y_nxt;
            sinal_q <= sinal_nxt;
            busy_q  <= busy_nxt;
            if (load_c) begin
                op_q  <= sel_op_c;
                a_q   <= sel_a_c;
                b_q   <= sel_b_c;
                win_q <= win_c;
`ifndef CALC_ARB_FIXED_PRIO_EN
                rr_q  <= win_c;
`endif
            end
        end
    end

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
- Shares one calculator arithmetic unit (soma/sub/multi on 7-bit unsigned operands, 14-bit result plus sign flag) between two requesters.
- Round-robin arbitration.
- Add/sub execute in a single cycle; multiply is a sequential shift-add taking WIDTH cycles.
- Sits between the front-panel/control FSMs and the display driver; replaces per-requester combinational ALUs.

Parameters:
- WIDTH, 7, operand width in bits; result width is 2*WIDTH.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  request per requester; bit i belongs to requester i; held high until done[i].
- op0  in  2  requester 0 opcode: 00 clear, 01 soma, 10 sub, 11 multi.
- a0, b0  in  WIDTH  requester 0 operands.
- op1  in  2  requester 1 opcode, same encoding.
- a1, b1  in  WIDTH  requester 1 operands.
- gnt  out  2  one-hot, single-cycle pulse; operands of the granted requester latched this cycle.
- done  out  2  one-hot, single-cycle pulse; y/sinal valid for that requester.
- y  out  2*WIDTH  result magnitude; holds the last value until the next done.
- sinal  out  1  1 when a sub result is negative (B>A); 0 for all other ops.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset: state=IDLE, gnt=0, done=0, y=0, sinal=0, busy=0, rr pointer=1 (requester 0 wins the first contention). Reset mid-operation aborts the operation immediately; no done is issued.
- States:
  - IDLE: if req!=0, select a winner, latch its op/a/b, assert gnt[winner] on the next cycle, then go to EXEC.
  - EXEC: compute, then go to DONE.
  - DONE: pulse done[winner], update y/sinal, then go to IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: the requester other than rr wins; rr updates to the winner on grant.
- Latency, counting from the cycle N in which IDLE samples req:
  - gnt at cycle N+1.
  - clear/soma/sub: done and new y at N+2.
  - multi: done at N+1+WIDTH.
  - IDLE is re-entered at the cycle after done, so back-to-back throughput is one op per 3 cycles (add/sub).
- Arithmetic:
  - clear: y=0.
  - soma: y=A+B, zero-extended, no overflow possible.
  - sub: if B>A then y=B-A and sinal=1, else y=A-B and sinal=0 (A==B gives 0, sinal=0).
  - multi: y=A*B via the shift-add sub-module; 0*x and x*0 still take full latency.
- Boundary rules:
  - Operands are sampled once at grant; later input changes are ignored.
  - req dropped mid-operation: the op still completes and done still pulses.
  - req still high when IDLE is re-entered: treated as a new request; the round-robin gives the other requester priority if it is asserting.
  - Max values (A=B=127): soma gives 254; multi gives 16129, which fits in 14 bits.
  - gnt and done never assert together; at most one bit of each is high.

Optional Feature:
- Macro: CALC_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins contention; the rr pointer is removed.
- Undefined (default): round-robin as above.
- Latency and all other behaviour are identical in both builds.

Decomposition:
- calc_pkg holds:
  - opcode localparams: OP_CLEAR, OP_SOMA, OP_SUB, OP_MULTI;
  - state encoding: IDLE, EXEC, DONE;
  - the default WIDTH constant.
- Sub-module calc_shift_mult:
  - Inputs: start, a, b.
  - Outputs: busy, ready, p (2*WIDTH bits).
  - Behaviour: one partial product per cycle; ready pulses after WIDTH cycles.
  - Reset: same asynchronous, active-low rst_n.

Test Plan:
- Reset, then req=01, op0=01, a0=100, b0=27 -> gnt=01 at N+1; done=01 at N+2 with y=127, sinal=0.
- req=10, op1=10, a1=5, b1=20 -> done=10 with y=15, sinal=1. Repeat with a1=b1=9 -> y=0, sinal=0.
- req=01, op0=11, a0=127, b0=127 -> done exactly 1+WIDTH=8 cycles after IDLE sample; y=16129. Changing a0 during EXEC has no effect on the result.
- Both requesters hold req=11 for 4 ops -> grant sequence 0,1,0,1. With CALC_ARB_FIXED_PRIO_EN defined -> 0,0,0,0.
- rst_n asserted low during the 4th multiply cycle -> all outputs 0 immediately; no done. After release, a new request is granted normally.
- Requester 0 drops req one cycle after gnt (op soma 3+4) -> done=01 still pulses with y=7; busy falls the cycle after done.
